// File: rtl/tc_pkg.sv
// Shared definitions for the traffic sensor conditioner.
// Holds the road/sensor index map, the special-service FSM encoding, the
// default filter and congestion lengths, and two small combinational helpers.
package tc_pkg;

    localparam int ROAD_A = 0;
    localparam int ROAD_B = 1;
    localparam int ROAD_C = 2;
    localparam int ROAD_D = 3;

    localparam int NUM_ROADS        = 4;
    localparam int SENSORS_PER_ROAD = 3;
    localparam int NUM_SS           = 4;
    localparam int NUM_INPUTS       = NUM_ROADS * SENSORS_PER_ROAD + NUM_SS;
    // Special-service channels sit above the road sensors in the input vector.
    localparam int SS_BASE          = NUM_ROADS * SENSORS_PER_ROAD;

    localparam int DEB_CYCLES_DEFAULT  = 4;
    localparam int CONG_CYCLES_DEFAULT = 8;

    typedef enum logic {
        SS_IDLE = 1'b0,
        SS_REQ  = 1'b1
    } ss_state_t;

    // Number of active sensors among a road's three.
    function automatic logic [1:0] count3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Lowest set bit of a 4-bit vector; 0 when the vector is empty.
    function automatic logic [1:0] lowest_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tc_debounce.sv
// Single-input conditioner: two-flop synchronizer followed by a debounce
// counter. The filtered value only flips after DEB_CYCLES consecutive
// synchronized samples disagree with it, so the raw-to-filtered latency is
// DEB_CYCLES+2 clock edges.
//
// Ports:
//   clock - rising-edge clock
//   clear - synchronous active-low reset
//   raw   - asynchronous raw input
//   filt  - debounced, synchronized output
module tc_debounce
    import tc_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic clear,
    input  logic raw,
    output logic filt
);

    logic       sync1;
    logic       sync2;
    logic [3:0] cnt;

    // The counter tracks how long sync2 has disagreed with filt; reaching
    // DEB_CYCLES-1 while still disagreeing means this is the DEB_CYCLES-th
    // differing sample, so the filter flips on this edge.
    always_ff @(posedge clock) begin
        if (!clear) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            filt  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != filt) begin
                if (cnt == 4'(DEB_CYCLES - 1)) begin
                    filt <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tc_sensor_conditioner.sv
// Front end for a four-road traffic controller. Conditions twelve vehicle
// sensors and four special-service requests, then derives per-road
// occupancy levels, latched service requests, congestion flags and a
// one-at-a-time special-service request handshake.
//
// Ports:
//   clock, clear           - clock and synchronous active-low reset
//   a1..d3                 - raw vehicle sensors, three per road
//   ss1..ss4               - raw special-service requests
//   serve[3:0]             - controller grant pulse per road
//   ss_ack                 - controller accepts presented special request
//   lvl_a..lvl_d[1:0]      - number of active filtered sensors per road
//   req[3:0]               - latched per-road service request
//   cong[3:0]              - per-road congestion flag
//   ss_req, ss_id[1:0]     - special-service request valid and its channel
module tc_sensor_conditioner
    import tc_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int CONG_CYCLES = CONG_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       ss1,
    input  logic       ss2,
    input  logic       ss3,
    input  logic       ss4,
    input  logic [3:0] serve,
    input  logic       ss_ack,
    output logic [1:0] lvl_a,
    output logic [1:0] lvl_b,
    output logic [1:0] lvl_c,
    output logic [1:0] lvl_d,
    output logic [3:0] req,
    output logic [3:0] cong,
    output logic       ss_req,
    output logic [1:0] ss_id
);

    localparam logic [7:0] CONG_MAX = 8'(CONG_CYCLES);

    logic [NUM_INPUTS-1:0] raw_in;
    logic [NUM_INPUTS-1:0] filt;
    logic [1:0]            lvl [NUM_ROADS];
    logic [7:0]            cong_cnt [NUM_ROADS];

    logic [NUM_SS-1:0] ss_filt;
    logic [NUM_SS-1:0] ss_prev;
    logic [NUM_SS-1:0] ss_rise;
    logic [NUM_SS-1:0] ss_pend;
    logic [NUM_SS-1:0] ss_mask;
    logic [NUM_SS-1:0] pend_clr;
    logic [1:0]        ss_id_next;
    ss_state_t         state;
    ss_state_t         state_next;

    assign raw_in[ROAD_A*SENSORS_PER_ROAD +: SENSORS_PER_ROAD] = {a3, a2, a1};
    assign raw_in[ROAD_B*SENSORS_PER_ROAD +: SENSORS_PER_ROAD] = {b3, b2, b1};
    assign raw_in[ROAD_C*SENSORS_PER_ROAD +: SENSORS_PER_ROAD] = {c3, c2, c1};
    assign raw_in[ROAD_D*SENSORS_PER_ROAD +: SENSORS_PER_ROAD] = {d3, d2, d1};
    assign raw_in[SS_BASE +: NUM_SS]                           = {ss4, ss3, ss2, ss1};

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
        tc_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clock(clock),
            .clear(clear),
            .raw  (raw_in[gi]),
            .filt (filt[gi])
        );
    end

    // Road bookkeeping. req and the congestion counter look at the
    // registered level, so they trail the level by one edge; serve wins
    // over a set in the same cycle and the request re-arms next edge.
    always_ff @(posedge clock) begin
        if (!clear) begin
            req <= '0;
            for (int r = 0; r < NUM_ROADS; r++) begin
                lvl[r]      <= 2'd0;
                cong_cnt[r] <= 8'd0;
            end
        end else begin
            for (int r = 0; r < NUM_ROADS; r++) begin
                lvl[r] <= count3(filt[r*SENSORS_PER_ROAD +: SENSORS_PER_ROAD]);
                req[r] <= (req[r] | (lvl[r] != 2'd0)) & ~serve[r];
                if (lvl[r] == 2'd3) begin
                    if (cong_cnt[r] != CONG_MAX) cong_cnt[r] <= cong_cnt[r] + 8'd1;
                end else begin
                    cong_cnt[r] <= 8'd0;
                end
            end
        end
    end

    for (genvar gr = 0; gr < NUM_ROADS; gr++) begin : g_cong
        assign cong[gr] = (cong_cnt[gr] == CONG_MAX);
    end

    assign lvl_a = lvl[ROAD_A];
    assign lvl_b = lvl[ROAD_B];
    assign lvl_c = lvl[ROAD_C];
    assign lvl_d = lvl[ROAD_D];

    assign ss_filt = filt[SS_BASE +: NUM_SS];
    assign ss_rise = ss_filt & ~ss_prev;

    // A rise on the channel being granted now, or on the one currently
    // presented, is masked so it cannot queue a duplicate request.
    always_comb begin
        state_next = state;
        ss_id_next = ss_id;
        pend_clr   = '0;
        ss_mask    = '0;
        case (state)
            SS_IDLE: begin
                if (|ss_pend) begin
                    state_next = SS_REQ;
                    ss_id_next = lowest_index(ss_pend);
                    pend_clr   = 4'(1) << lowest_index(ss_pend);
                    ss_mask    = 4'(1) << lowest_index(ss_pend);
                end
            end
            SS_REQ: begin
                ss_mask = 4'(1) << ss_id;
                if (ss_ack) state_next = SS_IDLE;
            end
            default: state_next = SS_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state   <= SS_IDLE;
            ss_id   <= 2'd0;
            ss_pend <= '0;
            ss_prev <= '0;
        end else begin
            state   <= state_next;
            ss_id   <= ss_id_next;
            ss_prev <= ss_filt;
            ss_pend <= (ss_pend & ~pend_clr) | (ss_rise & ~ss_mask);
        end
    end

    assign ss_req = (state == SS_REQ);

endmodule

// File: tb/tb_tc_sensor_conditioner.sv
// Bench for tc_sensor_conditioner with default parameters. Directed
// scenarios check fixed timings; a randomized run is compared cycle by
// cycle against a behavioural model stepped alongside the stimulus.
module tb_tc_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int CONG = 8;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] raw   = '0;
    logic [3:0]  serve = '0;
    logic        ss_ack = 1'b0;
    logic [1:0]  lvl_a, lvl_b, lvl_c, lvl_d;
    logic [3:0]  req, cong;
    logic        ss_req;
    logic [1:0]  ss_id;
    logic [18:0] dut_vec;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (value after the upcoming edge).
    logic [15:0]    m_s1 = '0, m_s2 = '0, m_filt = '0, m_rise = '0;
    logic [DEB-1:0] m_hist [16];
    logic [1:0]     m_lvl [4];
    int             m_run [4];
    logic [3:0]     m_req = '0, m_pend = '0;
    logic           m_busy = 1'b0;
    logic [1:0]     m_id = 2'd0;

    always #5 clock = ~clock;

    tc_sensor_conditioner #(.DEB_CYCLES(DEB), .CONG_CYCLES(CONG)) dut (
        .clock(clock), .clear(clear),
        .a1(raw[0]),  .a2(raw[1]),  .a3(raw[2]),
        .b1(raw[3]),  .b2(raw[4]),  .b3(raw[5]),
        .c1(raw[6]),  .c2(raw[7]),  .c3(raw[8]),
        .d1(raw[9]),  .d2(raw[10]), .d3(raw[11]),
        .ss1(raw[12]), .ss2(raw[13]), .ss3(raw[14]), .ss4(raw[15]),
        .serve(serve), .ss_ack(ss_ack),
        .lvl_a(lvl_a), .lvl_b(lvl_b), .lvl_c(lvl_c), .lvl_d(lvl_d),
        .req(req), .cong(cong), .ss_req(ss_req), .ss_id(ss_id)
    );

    assign dut_vec = {lvl_d, lvl_c, lvl_b, lvl_a, req, cong, ss_req, ss_id};

    // Advance the model by one edge using the inputs the DUT is about to see.
    task automatic model_step();
        int          granted;
        logic [1:0]  id_before;
        logic        busy_before;
        int          sum;
        if (!clear) begin
            m_s1 = '0; m_s2 = '0; m_filt = '0; m_rise = '0;
            m_pend = '0; m_busy = 1'b0; m_id = 2'd0; m_req = '0;
            for (int i = 0; i < 16; i++) m_hist[i] = '0;
            for (int r = 0; r < 4; r++) begin
                m_lvl[r] = 2'd0;
                m_run[r] = 0;
            end
        end else begin
            // Special service: grant lowest waiting channel, hold until ack.
            granted     = -1;
            id_before   = m_id;
            busy_before = m_busy;
            if (m_busy) begin
                if (ss_ack) m_busy = 1'b0;
            end else if (m_pend != 4'd0) begin
                for (int i = 3; i >= 0; i--) if (m_pend[i]) granted = i;
                m_busy = 1'b1;
                m_id = 2'(granted);
                m_pend[granted] = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_rise[12+i] && !(busy_before && i == int'(id_before)) && i != granted)
                    m_pend[i] = 1'b1;
            end
            // Roads: request and congestion follow the previous level.
            for (int r = 0; r < 4; r++) begin
                m_req[r] = (m_req[r] | (m_lvl[r] != 2'd0)) & ~serve[r];
                if (m_lvl[r] == 2'd3) begin
                    if (m_run[r] < 100000) m_run[r] = m_run[r] + 1;
                end else begin
                    m_run[r] = 0;
                end
                sum = int'(m_filt[3*r]) + int'(m_filt[3*r+1]) + int'(m_filt[3*r+2]);
                m_lvl[r] = 2'(sum);
            end
            // Filter flips once the last DEB samples all disagree with it.
            for (int i = 0; i < 16; i++) begin
                m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
                m_rise[i] = 1'b0;
                if (m_hist[i] == {DEB{~m_filt[i]}}) begin
                    m_rise[i] = ~m_filt[i];
                    m_filt[i] = ~m_filt[i];
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        clear = 1'b0; raw = '0; serve = '0; ss_ack = 1'b0;
        tick();
        tick();
        clear = 1'b1;
    endtask

    task automatic test_reset();
        clear = 1'b0; raw = '1; serve = '1; ss_ack = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            total++;
            if (dut_vec !== 19'd0) begin
                bad++;
                $display("[TB] FAIL reset_outputs e=%0d got=%h want=0", e, dut_vec);
            end
        end
        serve = '0; ss_ack = 1'b0;
    endtask

    task automatic test_short_pulse();
        logic [1:0] exp_lvl;
        logic       exp_req;
        for (int w = 1; w <= DEB; w++) begin
            do_reset();
            raw[0] = 1'b1;
            for (int e = 1; e <= 16; e++) begin
                if (e == w + 1) raw[0] = 1'b0;
                tick();
                exp_lvl = (w == DEB && e >= 7 && e <= 10) ? 2'd1 : 2'd0;
                exp_req = (w == DEB && e >= 8);
                total++;
                if (lvl_a !== exp_lvl || req[0] !== exp_req) begin
                    bad++;
                    $display("[TB] FAIL pulse w=%0d e=%0d got lvl_a=%0d req0=%b want lvl_a=%0d req0=%b",
                             w, e, lvl_a, req[0], exp_lvl, exp_req);
                end
            end
        end
    endtask

    task automatic test_congestion();
        logic [1:0] exp_lvl;
        logic       exp_cong, exp_req;
        do_reset();
        raw[2:0] = 3'b111;
        for (int e = 1; e <= 26; e++) begin
            if (e == 17) raw[2:0] = 3'b000;
            tick();
            exp_lvl  = (e >= 7 && e <= 22) ? 2'd3 : 2'd0;
            exp_cong = (e >= 15 && e <= 23);
            exp_req  = (e >= 8);
            total++;
            if (lvl_a !== exp_lvl || cong[0] !== exp_cong || req[0] !== exp_req) begin
                bad++;
                $display("[TB] FAIL congestion e=%0d got lvl=%0d cong=%b req=%b want lvl=%0d cong=%b req=%b",
                         e, lvl_a, cong[0], req[0], exp_lvl, exp_cong, exp_req);
            end
        end
    endtask

    task automatic test_serve();
        logic [1:0] exp_lvl;
        logic       exp_req;
        do_reset();
        raw[3] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            serve = (e == 10) ? 4'b0010 : 4'b0000;
            tick();
            exp_lvl = (e >= 7) ? 2'd1 : 2'd0;
            exp_req = (e >= 8 && e != 10);
            total++;
            if (lvl_b !== exp_lvl || req[1] !== exp_req) begin
                bad++;
                $display("[TB] FAIL serve e=%0d got lvl_b=%0d req1=%b want lvl_b=%0d req1=%b",
                         e, lvl_b, req[1], exp_lvl, exp_req);
            end
        end
        serve = '0;
    endtask

    task automatic test_ss_pair();
        logic       exp_req;
        logic [1:0] exp_id;
        do_reset();
        raw[12] = 1'b1;
        raw[14] = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            ss_ack = (e == 11 || e == 14 || e == 18);
            tick();
            exp_req = (e >= 8 && e <= 10) || (e >= 12 && e <= 13);
            exp_id  = (e >= 12) ? 2'd2 : 2'd0;
            total++;
            if (ss_req !== exp_req || (exp_req && ss_id !== exp_id)) begin
                bad++;
                $display("[TB] FAIL ss_pair e=%0d got req=%b id=%0d want req=%b id=%0d",
                         e, ss_req, ss_id, exp_req, exp_id);
            end
        end
        ss_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic       exp_req;
        logic [1:0] exp_lvl;
        do_reset();
        raw[2:0] = 3'b111;
        raw[13]  = 1'b1;
        for (int e = 1; e <= 16; e++) tick();
        total++;
        if (ss_req !== 1'b1 || ss_id !== 2'd1 || cong[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset got req=%b id=%0d cong0=%b want req=1 id=1 cong0=1",
                     ss_req, ss_id, cong[0]);
        end
        clear = 1'b0;
        tick();
        total++;
        if (dut_vec !== 19'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset got=%h want=0", dut_vec);
        end
        clear = 1'b1;
        for (int e = 18; e <= 40; e++) begin
            ss_ack = (e == 27);
            tick();
            exp_req = (e >= 25 && e <= 26);
            exp_lvl = (e >= 24) ? 2'd3 : 2'd0;
            total++;
            if (ss_req !== exp_req || (exp_req && ss_id !== 2'd1) || lvl_a !== exp_lvl) begin
                bad++;
                $display("[TB] FAIL after_reset e=%0d got req=%b id=%0d lvl=%0d want req=%b id=1 lvl=%0d",
                         e, ss_req, ss_id, lvl_a, exp_req, exp_lvl);
            end
        end
        ss_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [18:0] exp_vec;
        logic [3:0]  exp_cong;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 15) == 0) raw[i] = ~raw[i];
            end
            for (int r = 0; r < 4; r++) serve[r] = ($urandom_range(0, 7) == 0);
            ss_ack = ($urandom_range(0, 3) == 0);
            clear  = ($urandom_range(0, 299) != 0);
            tick();
            for (int r = 0; r < 4; r++) exp_cong[r] = (m_run[r] >= CONG);
            exp_vec = {m_lvl[3], m_lvl[2], m_lvl[1], m_lvl[0], m_req, exp_cong, m_busy, m_id};
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                if (bad < 20)
                    $display("[TB] FAIL random n=%0d got=%h want=%h", n, dut_vec, exp_vec);
            end
        end
        clear = 1'b1; serve = '0; ss_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_hist[i] = '0;
        for (int r = 0; r < 4; r++) begin
            m_lvl[r] = 2'd0;
            m_run[r] = 0;
        end
        @(negedge clock);
        test_reset();
        test_short_pulse();
        test_congestion();
        test_serve();
        test_ss_pair();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tc_sensor_conditioner.md
TC_SENSOR_CONDITIONER -- requirements
Module: tc_sensor_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive disagreeing samples required before a filtered input changes (range 2..15).
REQ-002 Parameter CONG_CYCLES, default 8: consecutive cycles at level 3 before a road flags congestion (range 1..255).
REQ-003 Port clock, input, 1: single clock; all logic rising-edge triggered.
REQ-004 Port clear, input, 1: synchronous, active-low reset.
REQ-005 Ports a1 a2 a3 / b1 b2 b3 / c1 c2 c3 / d1 d2 d3, input, 1 each: raw asynchronous vehicle sensors for roads A-D.
REQ-006 Ports ss1 ss2 ss3 ss4, input, 1 each: raw asynchronous special-service (emergency) requests.
REQ-007 Port serve, input, 4: bit r pulses when the controller grants road r (0=A..3=D).
REQ-008 Port ss_ack, input, 1: controller accepts the presented special-service request.
REQ-009 Ports lvl_a lvl_b lvl_c lvl_d, output, 2 each: count of filtered-active sensors on that road (0..3).
REQ-010 Port req, output, 4: latched per-road service request.
REQ-011 Port cong, output, 4: per-road congestion flag, consumed as the controller's maxout condition.
REQ-012 Port ss_req, output, 1: special-service request valid.
REQ-013 Port ss_id, output, 2: index of the requesting ss channel (0=ss1..3=ss4), valid while ss_req=1.

Function
REQ-014 Each of the 16 raw inputs SHALL pass a 2-flop synchronizer, then a debouncer.
REQ-015 Debouncer: counter increments while the synchronized value differs from the filtered value; counter clears on any agreement; the filtered value flips on the DEB_CYCLES-th consecutive differing sample and the counter clears.
REQ-016 Raw change to filtered change latency SHALL be exactly DEB_CYCLES+2 edges; pulses shorter than DEB_CYCLES cycles SHALL never reach the filtered value.
REQ-017 lvl_x SHALL be the registered popcount of the road's three filtered sensors (one edge after the filter change).
REQ-018 req[r] next = (req[r] OR lvl_r!=0) AND NOT serve[r]; serve wins in the same cycle; req re-sets on the following edge if lvl_r is still nonzero.
REQ-019 Per-road congestion counter increments while lvl_r==3, saturates at CONG_CYCLES, and clears when lvl_r<3; cong[r]=1 iff counter==CONG_CYCLES.
REQ-020 ss_pend[i] SHALL set on a rising edge of filtered ss_i only; a held ss input SHALL not retrigger.
REQ-021 SS FSM has states SS_IDLE and SS_REQ.
REQ-022 SS_IDLE -> SS_REQ when any ss_pend is set: ss_req<=1, ss_id<=lowest pending index, and that pend bit clears on the same edge.
REQ-023 In SS_REQ, ss_req and ss_id SHALL hold stable until ss_ack=1 is sampled; then -> SS_IDLE with ss_req<=0.
REQ-024 A minimum of one SS_IDLE cycle SHALL separate consecutive grants.
REQ-025 A rising edge on a channel already pending, or on the channel being presented, SHALL not create a duplicate request.
REQ-026 ss_ack while in SS_IDLE SHALL be ignored.

Reset
REQ-027 When clear==0 at a clock edge, all synchronizer flops, filtered values, counters, ss_pend, req, cong, lvl_x, ss_req and ss_id SHALL be 0, and the FSM SHALL be SS_IDLE.
REQ-028 Reset mid-operation SHALL drop an outstanding ss_req without ack; inputs already high at reset release SHALL be treated as fresh rising edges after debounce.

Structure
REQ-029 Shared package tc_pkg SHALL hold road index constants, the SS FSM state encoding, and DEB_CYCLES/CONG_CYCLES defaults.
REQ-030 Sub-module tc_debounce (synchronizer plus debounce counter, parameterised by DEB_CYCLES) SHALL be instantiated 16 times.

Verification (DEB_CYCLES=4, CONG_CYCLES=8)
REQ-031 a1=1 for 2 cycles -> lvl_a stays 0 and req[0] stays 0.
REQ-032 a1=a2=a3=1 held -> lvl_a=3 seven edges later, req[0]=1 one edge after that, cong[0]=1 eight edges after lvl_a=3; release -> cong[0]=0 one edge after lvl_a<3.
REQ-033 ss1 and ss3 rise in the same cycle -> ss_req=1 with ss_id=0; ss_ack for 1 cycle -> ss_req=0 for 1 cycle, then ss_req=1 with ss_id=2.
REQ-034 b1 held with lvl_b=1 and serve[1] pulsed -> req[1]=0 for exactly one cycle, then 1.
REQ-035 clear=0 while ss_req=1 and cong[0]=1 -> every output reads 0 after that edge; ss held through reset yields one new request after release.
